stack_mem_arbiter: RTL and testbench
====================================

Name: stack_mem_arbiter

Overview:
Shares the single-port instruction/data memory of the multicycle stack machine between two requesters: the instruction-fetch port (read-only, driven by the control FSM in FETCH) and the data port (stack spill/fill and MDR load/store). The block runs a small FSM that issues one memory command at a time, waits a fixed read latency, and returns read data to the owner with a valid pulse. It sits between the control/datapath and the memory macro.

Parameters:
ADDR_W, 5, memory address width (operand field of the 8-bit instruction)
DATA_W, 8, memory word width
RD_LAT, 2, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range ≥1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch read request (level)
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch command issued (1-cycle pulse)
if_rvalid  out  1  fetch read data valid (1-cycle pulse)
if_rdata  out  DATA_W  fetch read data
d_req  in  1  data request (level)
d_we  in  1  1=write, 0=read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_gnt  out  1  data command issued (1-cycle pulse)
d_rvalid  out  1  data read valid (1-cycle pulse)
d_rdata  out  DATA_W  data read data
mem_en  out  1  memory command strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; all gnt, rvalid, mem_en, mem_we, busy = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; counter = 0; last-owner = data. Any in-flight transaction is dropped with no rvalid.
- FSM states: IDLE, ISSUE, WAIT, RESP. Outputs are decoded from registered state and latched payload only; no combinational req→output paths.
- IDLE: requests sampled only here. If any req is high, pick a winner, latch owner/addr/we/wdata, and go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle): mem_en=1, mem_we=latched we (always 0 for fetch), mem_addr and mem_wdata come from latches, and the owner's gnt=1.
  - Write: next state is IDLE.
  - Read: next state is WAIT, counter loaded with RD_LAT-1.
- WAIT (RD_LAT cycles): counter decrements. When counter==0, capture mem_rdata into the owner's rdata register and go to RESP.
- RESP (1 cycle): owner's rvalid=1, then IDLE. rdata holds until that port's next read completes; the other port's rdata is untouched.
- Timing, req seen in IDLE at cycle 0:
  - gnt and mem_en at cycle 1.
  - Read rvalid at cycle 2+RD_LAT.
  - Write completes with busy low at cycle 2.
  - Next sample at cycle 2 (write) or 3+RD_LAT (read).
- Requester rule: hold req/addr/we/wdata stable until the clock edge where gnt=1. At that edge, drop req or present the next request. A req held high after gnt is a new request.
- Requests arriving while busy are not lost as long as req stays high; they are sampled at the next IDLE.
- Default arbitration is fixed priority, data over fetch. Fetch can starve while d_req is held.
- mem_addr/mem_wdata are don't-care when mem_en=0 but hold their latched value.

Optional Feature:
ARB_RR_EN
- Defined: round-robin on ties. The port not granted last wins. last-owner updates at each ISSUE and resets to data, so the first tie after reset goes to fetch. A lone requester always wins.
- Undefined: fixed priority data>fetch; last-owner register absent.

Test Plan:
- RD_LAT=2, reset released, if_req=1 if_addr=5'h03, mem_rdata=8'hA5 → if_gnt and mem_en with mem_addr=03, mem_we=0 at cycle 1; if_rvalid=1, if_rdata=A5 at cycle 4; d_rvalid stays 0.
- d_req=1 d_we=1 d_addr=5'h1F d_wdata=8'h3C → cycle 1: d_gnt=mem_en=mem_we=1, mem_addr=1F, mem_wdata=3C; busy=0 at cycle 2; no rvalid.
- if_req and d_req (read, addr 5'h07, mem_rdata=8'h11) both high at cycle 0, fixed priority → d_gnt cycle 1, d_rvalid with d_rdata=11 at cycle 4, if_gnt cycle 6.
- Same stimulus under ARB_RR_EN → if_gnt cycle 1 first, d_gnt cycle 6.
- Read issued, reset driven low during WAIT → mem_en=0, busy=0 immediately; no rvalid ever; after release a new if_req gets if_gnt one cycle after sampling.
- RD_LAT=1 instance, d read → d_gnt cycle 1, d_rvalid cycle 3. Back-to-back d writes with req held and payload changed at each gnt edge → d_gnt at cycles 1 and 3.

Source files
------------

// File: rtl/stack_mem_arbiter.sv
// Shares the stack machine's single-port memory between instruction fetch and the data port.
// Define ARB_RR_EN for round-robin arbitration on ties; otherwise data has fixed priority over fetch.
module stack_mem_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic                owner_fetch_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   if_rdata_q;
   logic [DATA_W-1:0]   d_rdata_q;
   logic                pick_fetch;

`ifdef ARB_RR_EN
   logic                last_fetch_q;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Winner is only meaningful in IDLE; a lone requester always wins.
   always_comb begin
      state_d    = state_q;
`ifdef ARB_RR_EN
      pick_fetch = if_req && (!d_req || !last_fetch_q);
`else
      pick_fetch = if_req && !d_req;
`endif
      case (state_q)
         ST_IDLE: begin
            if (if_req || d_req) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = we_q ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q         <= '0;
         owner_fetch_q <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         if_rdata_q    <= '0;
         d_rdata_q     <= '0;
`ifdef ARB_RR_EN
         last_fetch_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (if_req || d_req) begin
                  owner_fetch_q <= pick_fetch;
                  addr_q        <= pick_fetch ? if_addr : d_addr;
                  we_q          <= !pick_fetch && d_we;
                  if (!pick_fetch) begin
                     wdata_q <= d_wdata;
                  end
               end
            end
            ST_ISSUE: begin
               cnt_q <= CNT_W'(RD_LAT - 1);
`ifdef ARB_RR_EN
               last_fetch_q <= owner_fetch_q;
`endif
            end
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  if (owner_fetch_q) begin
                     if_rdata_q <= mem_rdata;
                  end else begin
                     d_rdata_q <= mem_rdata;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // All outputs decode from registered state and latched payload only.
   assign busy      = (state_q != ST_IDLE);
   assign mem_en    = (state_q == ST_ISSUE);
   assign mem_we    = mem_en && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_gnt    = mem_en && owner_fetch_q;
   assign d_gnt     = mem_en && !owner_fetch_q;
   assign if_rvalid = (state_q == ST_RESP) && owner_fetch_q;
   assign d_rvalid  = (state_q == ST_RESP) && !owner_fetch_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_stack_mem_arbiter.sv
// Directed bench for stack_mem_arbiter: an RD_LAT=2 and an RD_LAT=1 instance share stimulus.
// Arbitration expectations follow ARB_RR_EN when it is defined.
module tb_stack_mem_arbiter;

`ifdef ARB_RR_EN
   localparam bit rr_mode = 1'b1;
`else
   localparam bit rr_mode = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       if_req = 1'b0;
   logic [4:0] if_addr = '0;
   logic       d_req = 1'b0;
   logic       d_we = 1'b0;
   logic [4:0] d_addr = '0;
   logic [7:0] d_wdata = '0;
   logic [7:0] mem_rdata = '0;

   logic       if_gnt_l2, if_rvalid_l2, d_gnt_l2, d_rvalid_l2;
   logic       mem_en_l2, mem_we_l2, busy_l2;
   logic [7:0] if_rdata_l2, d_rdata_l2, mem_wdata_l2;
   logic [4:0] mem_addr_l2;

   logic       if_gnt_l1, if_rvalid_l1, d_gnt_l1, d_rvalid_l1;
   logic       mem_en_l1, mem_we_l1, busy_l1;
   logic [7:0] if_rdata_l1, d_rdata_l1, mem_wdata_l1;
   logic [4:0] mem_addr_l1;

   int check_count = 0;
   int error_count = 0;

   always #5 clk = ~clk;

   stack_mem_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(2)) u_dut_l2 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_l2),
      .if_rvalid(if_rvalid_l2), .if_rdata(if_rdata_l2),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt_l2), .d_rvalid(d_rvalid_l2), .d_rdata(d_rdata_l2),
      .mem_en(mem_en_l2), .mem_we(mem_we_l2), .mem_addr(mem_addr_l2),
      .mem_wdata(mem_wdata_l2), .mem_rdata(mem_rdata), .busy(busy_l2)
   );

   stack_mem_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) u_dut_l1 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_l1),
      .if_rvalid(if_rvalid_l1), .if_rdata(if_rdata_l1),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt_l1), .d_rvalid(d_rvalid_l1), .d_rdata(d_rdata_l1),
      .mem_en(mem_en_l1), .mem_we(mem_we_l1), .mem_addr(mem_addr_l1),
      .mem_wdata(mem_wdata_l1), .mem_rdata(mem_rdata), .busy(busy_l1)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Leaves the bench at a negedge with both DUTs idle; the caller's next drive is cycle 0.
   task automatic applyStimulus_reset();
      reset   = 1'b0;
      if_req  = 1'b0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      if_addr = '0;
      d_addr  = '0;
      d_wdata = '0;
      step(2);
      reset = 1'b1;
      step(1);
   endtask

   initial begin
      // Reset values while reset is held low
      step(1);
      checkOutput("rst_busy", busy_l2, 0);
      checkOutput("rst_mem_en", mem_en_l2, 0);
      checkOutput("rst_mem_we", mem_we_l2, 0);
      checkOutput("rst_gnts", {if_gnt_l2, d_gnt_l2}, 0);
      checkOutput("rst_rvalids", {if_rvalid_l2, d_rvalid_l2}, 0);
      checkOutput("rst_mem_addr", mem_addr_l2, 0);
      checkOutput("rst_mem_wdata", mem_wdata_l2, 0);
      checkOutput("rst_rdata", {if_rdata_l2, d_rdata_l2}, 0);

      // Fetch read, RD_LAT=2
      applyStimulus_reset();
      if_req = 1'b1; if_addr = 5'h03; mem_rdata = 8'hA5;
      step(1);
      checkOutput("t1_if_gnt_c1", if_gnt_l2, 1);
      checkOutput("t1_mem_en_c1", mem_en_l2, 1);
      checkOutput("t1_mem_we_c1", mem_we_l2, 0);
      checkOutput("t1_mem_addr_c1", mem_addr_l2, 5'h03);
      checkOutput("t1_d_gnt_c1", d_gnt_l2, 0);
      if_req = 1'b0;
      step(1);
      checkOutput("t1_mem_en_c2", mem_en_l2, 0);
      checkOutput("t1_busy_c2", busy_l2, 1);
      step(1);
      checkOutput("t1_if_rvalid_c3", if_rvalid_l2, 0);
      step(1);
      checkOutput("t1_if_rvalid_c4", if_rvalid_l2, 1);
      checkOutput("t1_if_rdata_c4", if_rdata_l2, 8'hA5);
      checkOutput("t1_d_rvalid_c4", d_rvalid_l2, 0);
      checkOutput("t1_d_rdata_c4", d_rdata_l2, 0);
      step(1);
      checkOutput("t1_if_rvalid_c5", if_rvalid_l2, 0);
      checkOutput("t1_busy_c5", busy_l2, 0);
      checkOutput("t1_if_rdata_hold", if_rdata_l2, 8'hA5);

      // Data write
      applyStimulus_reset();
      d_req = 1'b1; d_we = 1'b1; d_addr = 5'h1F; d_wdata = 8'h3C;
      step(1);
      checkOutput("t2_d_gnt_c1", d_gnt_l2, 1);
      checkOutput("t2_mem_en_c1", mem_en_l2, 1);
      checkOutput("t2_mem_we_c1", mem_we_l2, 1);
      checkOutput("t2_mem_addr_c1", mem_addr_l2, 5'h1F);
      checkOutput("t2_mem_wdata_c1", mem_wdata_l2, 8'h3C);
      checkOutput("t2_if_gnt_c1", if_gnt_l2, 0);
      d_req = 1'b0; d_we = 1'b0;
      step(1);
      checkOutput("t2_busy_c2", busy_l2, 0);
      checkOutput("t2_mem_en_c2", mem_en_l2, 0);
      checkOutput("t2_rvalids_c2", {if_rvalid_l2, d_rvalid_l2}, 0);
      checkOutput("t2_mem_addr_hold", mem_addr_l2, 5'h1F);
      step(2);
      checkOutput("t2_rvalids_c4", {if_rvalid_l2, d_rvalid_l2}, 0);

      // Simultaneous requests: fixed priority gives data first, round-robin gives fetch first
      applyStimulus_reset();
      if_req = 1'b1; if_addr = 5'h0A;
      d_req = 1'b1; d_we = 1'b0; d_addr = 5'h07; mem_rdata = 8'h11;
      step(1);
      checkOutput("t3_if_gnt_c1", if_gnt_l2, rr_mode ? 1 : 0);
      checkOutput("t3_d_gnt_c1", d_gnt_l2, rr_mode ? 0 : 1);
      checkOutput("t3_mem_addr_c1", mem_addr_l2, rr_mode ? 5'h0A : 5'h07);
      if_req = rr_mode ? 1'b0 : 1'b1;
      d_req  = rr_mode ? 1'b1 : 1'b0;
      step(3);
      checkOutput("t3_if_rvalid_c4", if_rvalid_l2, rr_mode ? 1 : 0);
      checkOutput("t3_d_rvalid_c4", d_rvalid_l2, rr_mode ? 0 : 1);
      checkOutput("t3_if_rdata_c4", if_rdata_l2, rr_mode ? 8'h11 : 8'h00);
      checkOutput("t3_d_rdata_c4", d_rdata_l2, rr_mode ? 8'h00 : 8'h11);
      mem_rdata = 8'h22;
      step(1);
      checkOutput("t3_gnts_c5", {if_gnt_l2, d_gnt_l2}, 0);
      step(1);
      checkOutput("t3_if_gnt_c6", if_gnt_l2, rr_mode ? 0 : 1);
      checkOutput("t3_d_gnt_c6", d_gnt_l2, rr_mode ? 1 : 0);
      checkOutput("t3_mem_addr_c6", mem_addr_l2, rr_mode ? 5'h07 : 5'h0A);
      if_req = 1'b0; d_req = 1'b0;
      step(3);
      checkOutput("t3_if_rvalid_c9", if_rvalid_l2, rr_mode ? 0 : 1);
      checkOutput("t3_d_rvalid_c9", d_rvalid_l2, rr_mode ? 1 : 0);
      checkOutput("t3_if_rdata_c9", if_rdata_l2, rr_mode ? 8'h11 : 8'h22);
      checkOutput("t3_d_rdata_c9", d_rdata_l2, rr_mode ? 8'h22 : 8'h11);

      // Reset asserted while a fetch read is waiting on memory
      applyStimulus_reset();
      if_req = 1'b1; if_addr = 5'h05; mem_rdata = 8'h77;
      step(1);
      checkOutput("t4_if_gnt_c1", if_gnt_l2, 1);
      if_req = 1'b0;
      step(1);
      checkOutput("t4_busy_wait", busy_l2, 1);
      #2 reset = 1'b0;
      #1;
      checkOutput("t4_busy_async", busy_l2, 0);
      checkOutput("t4_mem_en_async", mem_en_l2, 0);
      for (int i = 0; i < 3; i++) begin
         step(1);
         checkOutput("t4_no_rvalid", {if_rvalid_l2, d_rvalid_l2}, 0);
      end
      reset = 1'b1;
      step(1);
      checkOutput("t4_no_rvalid_post", {if_rvalid_l2, d_rvalid_l2}, 0);
      checkOutput("t4_if_rdata_dropped", if_rdata_l2, 0);
      if_req = 1'b1; if_addr = 5'h09;
      step(1);
      checkOutput("t4_if_gnt_after", if_gnt_l2, 1);
      checkOutput("t4_mem_addr_after", mem_addr_l2, 5'h09);
      if_req = 1'b0;
      step(3);
      checkOutput("t4_if_rvalid_after", if_rvalid_l2, 1);
      checkOutput("t4_if_rdata_after", if_rdata_l2, 8'h77);

      // RD_LAT=1 data read
      applyStimulus_reset();
      d_req = 1'b1; d_we = 1'b0; d_addr = 5'h02; mem_rdata = 8'h5A;
      step(1);
      checkOutput("t5_d_gnt_c1", d_gnt_l1, 1);
      checkOutput("t5_mem_addr_c1", mem_addr_l1, 5'h02);
      d_req = 1'b0;
      step(1);
      checkOutput("t5_d_rvalid_c2", d_rvalid_l1, 0);
      step(1);
      checkOutput("t5_d_rvalid_c3", d_rvalid_l1, 1);
      checkOutput("t5_d_rdata_c3", d_rdata_l1, 8'h5A);
      checkOutput("t5_if_rvalid_c3", if_rvalid_l1, 0);

      // RD_LAT=1 back-to-back writes with req held and payload swapped at each grant edge
      applyStimulus_reset();
      d_req = 1'b1; d_we = 1'b1; d_addr = 5'h01; d_wdata = 8'h10;
      step(1);
      checkOutput("t6_d_gnt_c1", d_gnt_l1, 1);
      checkOutput("t6_mem_wdata_c1", mem_wdata_l1, 8'h10);
      d_addr = 5'h02; d_wdata = 8'h20;
      step(1);
      checkOutput("t6_d_gnt_c2", d_gnt_l1, 0);
      checkOutput("t6_busy_c2", busy_l1, 0);
      step(1);
      checkOutput("t6_d_gnt_c3", d_gnt_l1, 1);
      checkOutput("t6_mem_we_c3", mem_we_l1, 1);
      checkOutput("t6_mem_addr_c3", mem_addr_l1, 5'h02);
      checkOutput("t6_mem_wdata_c3", mem_wdata_l1, 8'h20);
      d_req = 1'b0; d_we = 1'b0;
      step(1);
      checkOutput("t6_busy_c4", busy_l1, 0);
      checkOutput("t6_d_gnt_c4", d_gnt_l1, 0);

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
